dut_stim_gen: RTL and testbench

Synthesisable, parametrised stimulus generator for the `dut_if` slave port (cmd/adr/data). It replaces fixed-range, free-running bench stimulus with a constrained LFSR source. It supports configurable address and data ranges, three generation modes (random, sweep, unique-random), and a valid/ready handshake. On-chip address coverage tracking reports when every address in the range has been issued at least once.

---
 rtl/dut_stim_gen_if.sv | 29 ++
 rtl/dut_stim_gen.sv | 169 ++++++++++++++++
 tb/tb_dut_stim_gen.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dut_stim_gen_if.sv
// Beat channel out of the stimulus generator: cmd/adr/data payload under a valid/ready handshake.
// The master holds the payload stable while valid is high and ready is low.
interface dut_stim_gen_if #(
    parameter int ADR_W  = 4,
    parameter int DATA_W = 3,
    parameter int CMD_W  = 2
);
    logic              out_valid;
    logic              out_ready;
    logic [CMD_W-1:0]  out_cmd;
    logic [ADR_W-1:0]  out_adr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_cmd,
        output out_adr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_cmd,
        input  out_adr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/dut_stim_gen.sv
// Constrained LFSR beat generator (random / sweep / unique-random) with address coverage tracking.
// First beat 2 cycles after en; a stalled beat holds its payload and freezes the LFSR until ready.
module dut_stim_gen #(
    parameter int          ADR_W  = 4,
    parameter int          DATA_W = 3,
    parameter int          CMD_W  = 2,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [CMD_W-1:0]  cmd_cfg,
    input  logic [ADR_W-1:0]  adr_lo,
    input  logic [ADR_W-1:0]  adr_hi,
    input  logic [DATA_W-1:0] data_hi,
    dut_stim_gen_if.master    bus,
    output logic [ADR_W:0]    uniq_cnt,
    output logic              covered,
    output logic              done,
    output logic              cfg_err
);
    localparam logic [15:0]    SEED_I  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]    POLY    = 16'hB400;
    localparam logic [ADR_W-1:0] ADR_ONE = {{(ADR_W-1){1'b0}}, 1'b1};
    localparam logic [ADR_W:0]   CNT_ONE = {{ADR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_OFFER, S_DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_nxt;
    logic [1:0]          mode_q;
    logic [CMD_W-1:0]    cmd_q;
    logic [ADR_W-1:0]    lo_q;
    logic [ADR_W-1:0]    hi_q;
    logic [DATA_W-1:0]   dhi_q;
    logic [2**ADR_W-1:0] bitmap;
    logic [ADR_W-1:0]    ptr;
    logic [CMD_W-1:0]    cmd_r;
    logic [ADR_W-1:0]    adr_r;
    logic [DATA_W-1:0]   data_r;

    logic [ADR_W-1:0]    adr_c;
    logic [DATA_W-1:0]   data_c;
    logic                in_rng;
    logic                accept;
    logic                new_bit;
    logic [ADR_W:0]      uniq_nxt;
    logic [ADR_W:0]      range_sz;
    logic                last_uniq;

    assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0000);
    assign adr_c     = lfsr[ADR_W-1:0];
    assign data_c    = lfsr[ADR_W+DATA_W-1:ADR_W];
    assign in_rng    = (adr_c >= lo_q) && (adr_c <= hi_q);
    // mode_q is stored normalised, so 3 never reaches here and falls into the random rule
    assign accept    = (data_c <= dhi_q) &&
                       ((mode_q == 2'd1) || (in_rng && !((mode_q == 2'd2) && bitmap[adr_c])));
    assign new_bit   = ~bitmap[adr_r];
    assign uniq_nxt  = uniq_cnt + {{ADR_W{1'b0}}, new_bit};
    assign range_sz  = ({1'b0, hi_q} - {1'b0, lo_q}) + CNT_ONE;
    assign last_uniq = (mode_q == 2'd2) && (uniq_nxt == range_sz);
    assign covered   = (uniq_cnt == range_sz);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = (adr_lo > adr_hi) ? S_DONE : S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (accept) begin
                    state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (bus.out_ready) begin
                    if (last_uniq) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = en ? S_SEARCH : S_IDLE;
                    end
                end
            end
            S_DONE: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == S_OFFER);
        bus.out_cmd   = cmd_r;
        bus.out_adr   = adr_r;
        bus.out_data  = data_r;
        done          = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= SEED_I;
            mode_q   <= 2'd0;
            cmd_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            dhi_q    <= '0;
            bitmap   <= '0;
            ptr      <= '0;
            uniq_cnt <= '0;
            cfg_err  <= 1'b0;
            cmd_r    <= '0;
            adr_r    <= '0;
            data_r   <= '0;
        end else begin
            if (state == S_SEARCH) begin
                lfsr <= lfsr_nxt;
            end
            unique case (state)
                S_IDLE: begin
                    if (en) begin
                        mode_q   <= (mode == 2'd3) ? 2'd0 : mode;
                        cmd_q    <= cmd_cfg;
                        lo_q     <= adr_lo;
                        hi_q     <= adr_hi;
                        dhi_q    <= data_hi;
                        bitmap   <= '0;
                        uniq_cnt <= '0;
                        ptr      <= adr_lo;
                        cfg_err  <= (adr_lo > adr_hi);
                    end
                end
                S_SEARCH: begin
                    if (en && accept) begin
                        cmd_r  <= cmd_q;
                        adr_r  <= (mode_q == 2'd1) ? ptr : adr_c;
                        data_r <= data_c;
                    end
                end
                S_OFFER: begin
                    if (bus.out_ready) begin
                        bitmap[adr_r] <= 1'b1;
                        uniq_cnt      <= uniq_nxt;
                        if (mode_q == 2'd1) begin
                            ptr <= (ptr == hi_q) ? lo_q : ptr + ADR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dut_stim_gen.sv
// Scoreboard bench: expected beats come from filtering the LFSR stream by the acceptance rules.
module tb_dut_stim_gen;
    localparam int          ADR_W  = 4;
    localparam int          DATA_W = 3;
    localparam int          CMD_W  = 2;
    localparam logic [15:0] SEED   = 16'hACE1;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [1:0]        mode;
    logic [CMD_W-1:0]  cmd_cfg;
    logic [ADR_W-1:0]  adr_lo;
    logic [ADR_W-1:0]  adr_hi;
    logic [DATA_W-1:0] data_hi;
    logic [ADR_W:0]    uniq_cnt;
    logic              covered;
    logic              done;
    logic              cfg_err;

    dut_stim_gen_if #(.ADR_W(ADR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) bus ();

    dut_stim_gen #(.ADR_W(ADR_W), .DATA_W(DATA_W), .CMD_W(CMD_W), .SEED(SEED)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .cmd_cfg  (cmd_cfg),
        .adr_lo   (adr_lo),
        .adr_hi   (adr_hi),
        .data_hi  (data_hi),
        .bus      (bus),
        .uniq_cnt (uniq_cnt),
        .covered  (covered),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          hs_count = 0;
    beat_t       exp_q[$];
    logic [15:0] m_lfsr;
    bit          seen_m[16];
    int          m_uniq   = 0;
    int          m_range  = 1;
    bit          chk_uniq = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Every SEARCH cycle consumes one LFSR value, so the beat sequence is the stream filtered by the rules.
    task automatic gen_beats(input int m, input int lo, input int hi, input int dhi, input int cmd, input int n);
        int    ptr;
        int    pushed;
        int    a;
        int    d;
        bit    seen[16];
        beat_t b;
        ptr    = lo;
        pushed = 0;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        while (pushed < n) begin
            a      = int'(m_lfsr[3:0]);
            d      = int'(m_lfsr[6:4]);
            m_lfsr = lfsr_next(m_lfsr);
            if (d <= dhi) begin
                b.cmd  = CMD_W'(cmd);
                b.data = DATA_W'(d);
                if (m == 1) begin
                    b.adr = ADR_W'(ptr);
                    exp_q.push_back(b);
                    pushed++;
                    ptr = (ptr == hi) ? lo : ptr + 1;
                end else if (a >= lo && a <= hi && !(m == 2 && seen[a])) begin
                    b.adr = ADR_W'(a);
                    exp_q.push_back(b);
                    pushed++;
                    seen[a] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_uniq) begin
            check("uniq_cnt", int'(uniq_cnt), m_uniq);
            check("covered", int'(covered), int'(m_uniq == m_range));
            chk_uniq = 1'b0;
        end
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_adr", int'(bus.out_adr), -1);
            end else begin
                check("beat_cmd", int'(bus.out_cmd), int'(exp_q[0].cmd));
                check("beat_adr", int'(bus.out_adr), int'(exp_q[0].adr));
                check("beat_data", int'(bus.out_data), int'(exp_q[0].data));
                if (bus.out_ready) begin
                    if (!seen_m[exp_q[0].adr]) begin
                        seen_m[exp_q[0].adr] = 1'b1;
                        m_uniq++;
                    end
                    void'(exp_q.pop_front());
                    hs_count++;
                    chk_uniq = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cfg(input int m, input int lo, input int hi, input int dhi, input int cmd);
        mode    = 2'(m);
        adr_lo  = ADR_W'(lo);
        adr_hi  = ADR_W'(hi);
        data_hi = DATA_W'(dhi);
        cmd_cfg = CMD_W'(cmd);
        for (int i = 0; i < 16; i++) seen_m[i] = 1'b0;
        m_uniq  = 0;
        m_range = hi - lo + 1;
        en      = 1'b1;
    endtask

    task automatic wait_valid(input string name, output int k);
        k = 0;
        while (!bus.out_valid && k < 200) begin
            tick();
            k++;
        end
        if (!bus.out_valid) check(name, 0, 1);
    endtask

    // Drives one run of n beats; en drops only while a beat is offered so the LFSR stream stays aligned.
    task automatic run(input int m, input int lo, input int hi, input int dhi, input int cmd,
                       input int n_in, input bit rnd_ready, output int cycles);
        int em;
        int n;
        int target;
        em = (m == 3) ? 0 : m;
        n  = (em == 2) ? (hi - lo + 1) : n_in;
        gen_beats(em, lo, hi, dhi, cmd, n);
        target = hs_count + n;
        start_cfg(m, lo, hi, dhi, cmd);
        bus.out_ready = 1'b1;
        cycles = 0;
        while (hs_count < target && cycles < 20000) begin
            tick();
            cycles++;
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (em != 2 && bus.out_valid && hs_count == target - 1) en = 1'b0;
        end
        if (hs_count < target) check("run_timeout", hs_count, target);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int k;
        int hs0;
        int lo;
        int hi;
        rst = 1'b1; en = 1'b0; mode = 2'd0; cmd_cfg = '0;
        adr_lo = '0; adr_hi = '0; data_hi = '0; bus.out_ready = 1'b0;
        m_lfsr = SEED;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_uniq", int'(uniq_cnt), 0);
        check("rst_covered", int'(covered), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_payload", int'({bus.out_cmd, bus.out_adr, bus.out_data}), 0);

        // Reset while a beat is pending: beat dropped, LFSR back at seed
        gen_beats(0, 0, 15, 7, 1, 1);
        start_cfg(0, 0, 15, 7, 1);
        wait_valid("first_valid_timeout", k);
        check("first_valid_latency", k, 2);
        repeat (5) begin
            tick();
            check("stall_valid", int'(bus.out_valid), 1);
        end
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst_valid", int'(bus.out_valid), 0);
        check("midrst_uniq", int'(uniq_cnt), 0);
        check("midrst_done", int'(done), 0);
        exp_q.delete();
        m_lfsr = SEED;
        tick();

        // Sweep: one beat every 2 cycles with full data range and ready high
        run(1, 14, 15, 7, 0, 4, 1'b0, cyc);
        check("m1_cycles", cyc, 9);
        check("m1_uniq", int'(uniq_cnt), 2);
        check("m1_covered", int'(covered), 1);
        check("m1_idle_valid", int'(bus.out_valid), 0);
        repeat (2) tick();

        run(0, 5, 15, 7, 3, 500, 1'b1, cyc);
        check("m0_covered", int'(covered), 1);
        check("m0_uniq", int'(uniq_cnt), 11);
        repeat (2) tick();

        run(2, 5, 15, 7, 1, 0, 1'b1, cyc);
        check("m2_done", int'(done), 1);
        check("m2_valid", int'(bus.out_valid), 0);
        check("m2_uniq", int'(uniq_cnt), 11);
        en = 1'b0;
        tick();
        check("m2_idle_done", int'(done), 0);
        repeat (2) tick();

        // Backpressure with en dropped mid-stall
        gen_beats(0, 2, 12, 5, 2, 1);
        hs0 = hs_count;
        start_cfg(0, 2, 12, 5, 2);
        wait_valid("bp_valid_timeout", k);
        en = 1'b0;
        repeat (5) begin
            tick();
            check("bp_hold_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_handshakes", hs_count - hs0, 1);
        check("bp_after_valid", int'(bus.out_valid), 0);
        tick();
        check("bp_idle_valid", int'(bus.out_valid), 0);
        check("bp_idle_done", int'(done), 0);
        repeat (2) tick();

        // Inverted range
        start_cfg(0, 9, 3, 7, 0);
        tick();
        check("cfg_done", int'(done), 1);
        check("cfg_err_set", int'(cfg_err), 1);
        check("cfg_valid", int'(bus.out_valid), 0);
        tick();
        en = 1'b0;
        tick();
        check("cfg_err_sticky", int'(cfg_err), 1);
        check("cfg_idle_done", int'(done), 0);
        run(1, 3, 6, 4, 2, 6, 1'b1, cyc);
        check("cfg_err_cleared", int'(cfg_err), 0);
        repeat (2) tick();

        run(3, 0, 7, 3, 2, 10, 1'b1, cyc);
        repeat (2) tick();

        for (int r = 0; r < 8; r++) begin
            lo = $urandom_range(0, 15);
            hi = $urandom_range(lo, 15);
            run($urandom_range(0, 3), lo, hi, $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(3, 20), 1'b1, cyc);
            en = 1'b0;
            repeat (2) tick();
        end
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
